// File: rtl/libv_rr_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// libv_rr_dispatch_pkg
// Shared width helpers for the round-robin dispatcher and its lane registers.
//   lane_idx_w(n) : bits needed to encode a lane index among n lanes (min 1)
//   lane_cnt_w(n) : bits needed to count 0..n occupied lanes
// ----------------------------------------------------------------------------
package libv_rr_dispatch_pkg;

    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lane_cnt_w(input int n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/libv_rr_dispatch_lane.sv
// ----------------------------------------------------------------------------
// libv_rr_dispatch_lane
// One-entry holding register for a single output lane.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-low reset (clears valid only)
//   load_i    in   capture data_i this cycle
//   rdy_i     in   downstream ready for this lane
//   data_i    in   DW-bit word to capture
//   vld_o     out  holding register valid
//   data_o    out  held word
// ----------------------------------------------------------------------------
module libv_rr_dispatch_lane #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          rdy_i,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    output logic [DW-1:0] data_o
);

    logic          vld_q, vld_d;
    logic [DW-1:0] data_q;

    // A reload in the same cycle as a drain keeps the lane valid with the new word.
    always_comb begin
        vld_d = vld_q;
        if (load_i)
            vld_d = 1'b1;
        else if (vld_q && rdy_i)
            vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            vld_q <= 1'b0;
        else
            vld_q <= vld_d;
    end

    // Data path is not reset; a cleared valid already discards the held word.
    always_ff @(posedge clk) begin
        if (load_i)
            data_q <= data_i;
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/libv_rr_dispatch.sv
// ----------------------------------------------------------------------------
// libv_rr_dispatch
// Distributes a single input word stream one word per cycle across W lanes in
// round-robin order. Each lane owns a one-entry holding register.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-low reset
//   in_vld    in   upstream word valid
//   in_data   in   upstream word (DW)
//   in_rdy    out  at least one lane can take a word this cycle
//   out_vld   out  per-lane valid (W)
//   out_data  out  per-lane word, lane i at [i*DW +: DW]
//   out_rdy   in   per-lane downstream ready (W)
//   dsp_enc   out  lane index chosen for the current accept
//   busy_cnt  out  number of lanes currently holding a word
// ----------------------------------------------------------------------------
module libv_rr_dispatch
    import libv_rr_dispatch_pkg::*;
#(
    parameter int W  = 4,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [DW-1:0]            in_data,
    output logic                     in_rdy,
    output logic [W-1:0]             out_vld,
    output logic [W*DW-1:0]          out_data,
    input  logic [W-1:0]             out_rdy,
    output logic [lane_idx_w(W)-1:0] dsp_enc,
    output logic [lane_cnt_w(W)-1:0] busy_cnt
);

    localparam int IW = lane_idx_w(W);
    localparam int CW = lane_cnt_w(W);

    logic [W-1:0]  idx_q;
    logic [W-1:0]  free, above, cand_hi, sel_hi, sel_lo, sel, idx_rot, load;
    logic [IW-1:0] enc;
    logic [CW-1:0] cnt;
    logic          accept;

    // Selection: lowest free lane at or above idx, else lowest free lane overall.
    always_comb begin
        free   = ~out_vld | out_rdy;
        above  = '0;
        sel_hi = '0;
        sel_lo = '0;
        for (int i = 0; i < W; i++) begin
            above[i] = (i == 0) ? idx_q[0] : (above[i-1] | idx_q[i]);
        end
        cand_hi = free & above;
        // Descending scan so the lowest matching lane overwrites last.
        for (int i = W - 1; i >= 0; i--) begin
            if (cand_hi[i]) sel_hi = W'(1) << i;
            if (free[i])    sel_lo = W'(1) << i;
        end
        sel = (|cand_hi) ? sel_hi : sel_lo;
    end

    always_comb begin
        enc     = '0;
        idx_rot = '0;
        for (int i = 0; i < W; i++) begin
            if (sel[i]) enc = i[IW-1:0];
            idx_rot[(i + 1) % W] = sel[i];
        end
    end

    assign in_rdy  = |free;
    assign accept  = in_vld && in_rdy;
    assign load    = accept ? sel : '0;
    assign dsp_enc = enc;

    always_ff @(posedge clk) begin
        if (!rst)
            idx_q <= W'(1);
        else if (accept)
            idx_q <= idx_rot;
    end

    for (genvar g = 0; g < W; g++) begin : g_lane
        libv_rr_dispatch_lane #(.DW(DW)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[g]),
            .rdy_i  (out_rdy[g]),
            .data_i (in_data),
            .vld_o  (out_vld[g]),
            .data_o (out_data[g*DW +: DW])
        );
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(out_vld[i]);
        end
    end

    assign busy_cnt = cnt;

endmodule

// File: tb/tb_libv_rr_dispatch.sv
module tb_libv_rr_dispatch;

    localparam int W  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld;
    logic [DW-1:0]     in_data;
    logic              in_rdy;
    logic [W-1:0]      out_vld;
    logic [W*DW-1:0]   out_data;
    logic [W-1:0]      out_rdy;
    logic [1:0]        dsp_enc;
    logic [2:0]        busy_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    libv_rr_dispatch #(.W(W), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .dsp_enc  (dsp_enc),
        .busy_cnt (busy_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input int i);
        return out_data[i*DW +: DW];
    endfunction

    // Offer one word with the given readies; check combinational selection,
    // then clock it in.
    task automatic offer(input string tag, input logic [DW-1:0] d, input logic [W-1:0] rdy,
                         input logic exp_rdy, input logic [1:0] exp_enc);
        in_vld  = 1'b1;
        in_data = d;
        out_rdy = rdy;
        #1;
        chk({tag, "_rdy"}, 64'(in_rdy), 64'(exp_rdy));
        if (exp_rdy) chk({tag, "_enc"}, 64'(dsp_enc), 64'(exp_enc));
        cyc();
    endtask

    initial begin
        rst     = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = '0;
        cyc();
        cyc();
        chk("rst_vld", 64'(out_vld), 64'h0);
        chk("rst_busy", 64'(busy_cnt), 64'h0);
        rst = 1'b1;
        cyc();
        chk("post_rst_rdy", 64'(in_rdy), 64'h1);

        // Full throughput round robin with all lanes ready.
        for (int k = 0; k < 5; k++) begin
            offer($sformatf("rr%0d", k), DW'(32'h10 + k), 4'b1111, 1'b1, 2'(k % 4));
            chk($sformatf("rr%0d_vld", k), 64'(out_vld[k % 4]), 64'h1);
            chk($sformatf("rr%0d_data", k), 64'(lane(k % 4)), 64'(32'h10 + k));
        end
        in_vld = 1'b0;
        cyc();
        chk("drain_busy", 64'(busy_cnt), 64'h0);

        // Fresh start, then fill all lanes with nothing draining.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer($sformatf("fill%0d", k), DW'(32'h20 + k), 4'b0000, 1'b1, 2'(k));
        end
        chk("fill_vld", 64'(out_vld), 64'hf);
        chk("fill_busy", 64'(busy_cnt), 64'h4);
        offer("full", 32'h24, 4'b0000, 1'b0, 2'd0);
        chk("full_busy", 64'(busy_cnt), 64'h4);
        chk("full_lane0", 64'(lane(0)), 64'h20);
        // Lane 2 drains and reloads in the same cycle.
        offer("reload", 32'h24, 4'b0100, 1'b1, 2'd2);
        chk("reload_vld2", 64'(out_vld[2]), 64'h1);
        chk("reload_data2", 64'(lane(2)), 64'h24);
        chk("reload_busy", 64'(busy_cnt), 64'h4);
        in_vld  = 1'b0;
        out_rdy = 4'b0000;
        cyc();
        chk("hold_data2", 64'(lane(2)), 64'h24);

        // Reset with all lanes full discards everything.
        rst = 1'b0;
        cyc();
        chk("mid_rst_vld", 64'(out_vld), 64'h0);
        chk("mid_rst_busy", 64'(busy_cnt), 64'h0);
        rst = 1'b1;
        offer("after_rst", 32'h30, 4'b0000, 1'b1, 2'd0);
        chk("after_rst_vld", 64'(out_vld), 64'h1);
        chk("after_rst_data", 64'(lane(0)), 64'h30);

        // Fill remaining lanes: idx wraps back to lane 0.
        offer("f1", 32'h31, 4'b0000, 1'b1, 2'd1);
        offer("f2", 32'h32, 4'b0000, 1'b1, 2'd2);
        offer("f3", 32'h33, 4'b0000, 1'b1, 2'd3);
        // Lane 0 reloads, lane 2 drains; idx moves to lane 1.
        offer("mix", 32'h34, 4'b0101, 1'b1, 2'd0);
        chk("mix_vld", 64'(out_vld), 64'hb);
        chk("mix_busy", 64'(busy_cnt), 64'h3);
        // idx=1, lane 1 blocked -> lane 2, idx becomes 3.
        offer("skip", 32'h35, 4'b0000, 1'b1, 2'd2);
        chk("skip_data2", 64'(lane(2)), 64'h35);
        offer("idx3", 32'h36, 4'b1111, 1'b1, 2'd3);
        offer("wrap", 32'h37, 4'b1111, 1'b1, 2'd0);
        in_vld = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        chk("idle_busy", 64'(busy_cnt), 64'h0);
        offer("idle_idx", 32'h38, 4'b1111, 1'b1, 2'd1);
        chk("idle_data1", 64'(lane(1)), 64'h38);
        in_vld = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/libv_rr_dispatch.md
LIBV_RR_DISPATCH -- requirements
Module: libv_rr_dispatch

Interface
REQ-001 The block SHALL have parameter W, 4, number of output lanes (W >= 1).
REQ-002 The block SHALL have parameter DW, 32, data width per word.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 Port: in_vld  input  1  upstream word valid.
REQ-006 Port: in_data  input  DW  upstream word.
REQ-007 Port: in_rdy  output  1  block can accept in_data this cycle.
REQ-008 Port: out_vld  output  W  per-lane holding-register valid.
REQ-009 Port: out_data  output  W*DW  per-lane word; lane i at bits [i*DW +: DW].
REQ-010 Port: out_rdy  input  W  per-lane downstream ready.
REQ-011 Port: dsp_enc  output  $clog2(W) (min 1)  lane index of the current accept; meaningful only when in_vld && in_rdy.
REQ-012 Port: busy_cnt  output  $clog2(W+1)  number of lanes with out_vld set.

Function
REQ-013 The block SHALL distribute single-stream input words one per cycle to W lanes in round-robin order (1-to-N counterpart of an N-to-1 arbiter).
REQ-014 Each lane SHALL have a one-entry holding register; lane free_i = !out_vld[i] || out_rdy[i].
REQ-015 A one-hot pointer idx SHALL mark the highest-priority lane; selection = first free lane at or above idx, wrapping to lane 0 upward when none.
REQ-016 in_rdy SHALL equal OR of free_i (combinational from out_rdy and out_vld).
REQ-017 An accept (in_vld && in_rdy) SHALL load in_data into the selected lane and set its out_vld the next cycle (latency 1).
REQ-018 On accept, idx SHALL become the selected lane rotated left by one (lane W-1 wraps to lane 0); without an accept idx SHALL hold.
REQ-019 A lane with out_vld && out_rdy and no reload SHALL clear out_vld next cycle; drain and reload in the same cycle SHALL keep out_vld=1 with the new word.
REQ-020 A lane with out_vld && !out_rdy SHALL hold out_data stable.
REQ-021 in_vld with in_rdy=0 SHALL leave all state unchanged; in_data is not captured.
REQ-022 busy_cnt SHALL equal popcount(out_vld) registered state, range 0..W.
REQ-023 W=1 SHALL degenerate to a single one-entry register; idx constant 1.
REQ-024 Full throughput: with all out_rdy=1 and in_vld=1, one word SHALL be accepted every cycle.

Reset
REQ-025 While rst=0: out_vld=0, busy_cnt=0, idx=lane 0 (one-hot 'b1); in_rdy=1 in the first cycle after reset deasserts.
REQ-026 out_data SHALL NOT be reset; reset mid-operation SHALL discard all held words.

Structure
REQ-027 Register macros SHALL come from the shared libv_pkg include; no new package typedefs are required beyond a lane-index width constant derived from W.
REQ-028 One sub-module, libv_rr_dispatch_lane (holding register: load, drain, valid), SHALL be instantiated W times; selection logic lives in the top.

Verification (W=4, DW=32)
REQ-029 Reset, out_rdy=4'b1111, in_vld=1, data 0x10,0x11,... -> lanes 0,1,2,3,0 receive 0x10..0x14 on consecutive cycles, in_rdy=1 throughout.
REQ-030 out_rdy=0, 5 words offered -> lanes 0..3 filled, in_rdy=0 on 5th, busy_cnt=4; raise out_rdy[2] -> 5th word to lane 2 same cycle, out_vld[2] stays 1, busy_cnt stays 4.
REQ-031 idx=lane 1, lane 1 held full with out_rdy[1]=0 -> next word to lane 2, dsp_enc=2, idx becomes lane 3.
REQ-032 idx=lane 3, accept -> next idx=lane 0 (wrap); in_vld=0 for 10 cycles -> idx unchanged.
REQ-033 All lanes full, rst=0 one cycle -> out_vld=0, busy_cnt=0; next offered word goes to lane 0.
